pwm_duty_ramp: RTL and testbench

//  Upstream stage of the PWM generator. Accepts a target duty word over a valid/ready handshake.

---
 rtl/pwm_ramp_pkg.sv | 28 ++
 rtl/pwm_duty_ramp_if.sv | 21 ++
 rtl/pwm_ramp_prescaler.sv | 31 +++
 rtl/pwm_duty_ramp.sv | 114 +++++++++++
 tb/tb_pwm_duty_ramp.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_ramp_pkg.sv
// Shared types, default widths and slew arithmetic for the PWM duty ramp.
// Optional retarget-during-ramp feature: PWM_RAMP_RETARGET_EN.
package pwm_ramp_pkg;

   localparam int DW_D      = 8;
   localparam int SW_D      = 4;
   localparam int PRESC_W_D = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   // One slew step toward tgt, clamped at tgt so it never overshoots or wraps.
   function automatic int unsigned ramp_step(
      input int unsigned duty,
      input int unsigned tgt,
      input int unsigned stp
   );
      if (tgt > duty)
         return (duty + stp >= tgt) ? tgt : duty + stp;
      else if (duty < tgt + stp)
         return tgt;
      else
         return duty - stp;
   endfunction

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Target-duty valid/ready channel into the PWM duty ramp.
// Master offers a duty word, slave accepts on valid && ready.
interface pwm_duty_ramp_if #(
   parameter int DW = 8
);
   logic          tgt_valid;
   logic          tgt_ready;
   logic [DW-1:0] tgt_duty;

   modport master (
      output tgt_valid,
      output tgt_duty,
      input  tgt_ready
   );

   modport slave (
      input  tgt_valid,
      input  tgt_duty,
      output tgt_ready
   );
endinterface

// File: rtl/pwm_ramp_prescaler.sv
// Counts PWM period starts and pulses upd every ramp_div+1 of them.
// Held clear while clr is high; frozen while ena is low.
module pwm_ramp_prescaler #(
   parameter int PRESC_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               clr,
   input  logic               period_start,
   input  logic [PRESC_W-1:0] ramp_div,
   output logic               upd
);

   logic [PRESC_W-1:0] pcnt_q;

   // >= so a live shrink of ramp_div below pcnt fires at once instead of wrapping.
   assign upd = ena && !clr && period_start && (pcnt_q >= ramp_div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
      end else if (ena) begin
         if (clr || upd)
            pcnt_q <= '0;
         else if (period_start)
            pcnt_q <= pcnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slews duty_o toward an accepted target once every ramp_div+1 PWM periods.
// Define PWM_RAMP_RETARGET_EN to allow a new target to be accepted mid-ramp.
module pwm_duty_ramp
   import pwm_ramp_pkg::*;
#(
   parameter int DW      = DW_D,
   parameter int SW      = SW_D,
   parameter int PRESC_W = PRESC_W_D
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   pwm_duty_ramp_if.slave     tgt,
   input  logic [SW-1:0]      step,
   input  logic [PRESC_W-1:0] ramp_div,
   input  logic               period_start,
   output logic [DW-1:0]      duty_o,
   output logic               busy,
   output logic               done
);

   state_t        state_q, state_d;
   logic [DW-1:0] tgt_q, tgt_d;
   logic [DW-1:0] duty_q, duty_d;
   logic          done_q, done_d;
   logic [SW-1:0] stp;
   logic [DW-1:0] duty_step;
   logic          accept;
   logic          upd;

`ifdef PWM_RAMP_RETARGET_EN
   assign tgt.tgt_ready = ena;
`else
   assign tgt.tgt_ready = ena && (state_q == ST_IDLE);
`endif

   assign accept    = tgt.tgt_valid && tgt.tgt_ready;
   assign stp       = (step == '0) ? SW'(1) : step;
   assign duty_step = DW'(ramp_step(32'(duty_q), 32'(tgt_q), 32'(stp)));

   assign duty_o = duty_q;
   assign busy   = (state_q == ST_RAMP);
   assign done   = done_q;

   pwm_ramp_prescaler #(
      .PRESC_W(PRESC_W)
   ) u_presc (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .clr          (state_q == ST_IDLE),
      .period_start (period_start),
      .ramp_div     (ramp_div),
      .upd          (upd)
   );

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      duty_d  = duty_q;
      done_d  = ena ? 1'b0 : done_q;
      if (ena) begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  tgt_d = tgt.tgt_duty;
                  if (tgt.tgt_duty == duty_q)
                     done_d = 1'b1;
                  else
                     state_d = ST_RAMP;
               end
            end
            ST_RAMP: begin
               if (upd) begin
                  duty_d = duty_step;
                  if (duty_step == tgt_q) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
`ifdef PWM_RAMP_RETARGET_EN
               // The step above used the old target; the new one takes over after it.
               if (accept) begin
                  tgt_d = tgt.tgt_duty;
                  if (tgt.tgt_duty == duty_d) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     done_d  = 1'b0;
                     state_d = ST_RAMP;
                  end
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tgt_q   <= '0;
         duty_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         duty_q  <= duty_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: expected duty/done events are
// queued with the stimulus and checked by an independent monitor.
module tb_pwm_duty_ramp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [3:0]  step;
   logic [15:0] ramp_div;
   logic        period_start;
   logic [7:0]  duty_o;
   logic        busy;
   logic        done;

   typedef struct {
      int d;
      int dn;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   prev   = 0;

   always #5 clk = ~clk;

   pwm_duty_ramp_if #(.DW(8)) tif ();

   pwm_duty_ramp #(
      .DW      (8),
      .SW      (4),
      .PRESC_W (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .tgt          (tif),
      .step         (step),
      .ramp_div     (ramp_div),
      .period_start (period_start),
      .duty_o       (duty_o),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int d, input int dn);
      exp_t e;
      e.d  = d;
      e.dn = dn;
      q.push_back(e);
   endtask

   task automatic send(input int v);
      int n;
      n = 0;
      tif.tgt_valid = 1'b1;
      tif.tgt_duty  = 8'(v);
      while (!tif.tgt_ready && n < 20) begin
         tick();
         n++;
      end
      chk("send_ready", int'(tif.tgt_ready), 1);
      tick();
      tif.tgt_valid = 1'b0;
   endtask

   task automatic pulse(input int n);
      for (int i = 0; i < n; i++) begin
         period_start = 1'b1;
         tick();
         period_start = 1'b0;
         tick();
      end
   endtask

   // Monitor: any duty change or done pulse is an output event.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
      end else if (int'(duty_o) != prev || done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got duty=%0d done=%0d want none",
                     duty_o, done);
         end else begin
            e = q.pop_front();
            chk("ev_duty", int'(duty_o), e.d);
            chk("ev_done", int'(done), e.dn);
         end
      end
      prev = int'(duty_o);
   end

   initial begin
      int d;
      rst_n         = 1'b0;
      ena           = 1'b1;
      step          = 4'd4;
      ramp_div      = 16'd0;
      period_start  = 1'b0;
      tif.tgt_valid = 1'b0;
      tif.tgt_duty  = 8'd0;
      #12;
      chk("rst_duty", int'(duty_o), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(tif.tgt_ready), 1);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: 0 -> 10, step 4, one update per period
      push(4, 0);
      push(8, 0);
      push(10, 1);
      send(10);
      chk("t1_busy_on", int'(busy), 1);
      pulse(3);
      chk("t1_busy_off", int'(busy), 0);
      chk("t1_duty", int'(duty_o), 10);

      // 2: 10 -> 0, step 3, every 3rd period
      step     = 4'd3;
      ramp_div = 16'd2;
      push(7, 0);
      push(4, 0);
      push(1, 0);
      push(0, 1);
      send(0);
      pulse(12);
      chk("t2_duty", int'(duty_o), 0);

      // 3: climb to 250, then 250 -> 255 in one clamped step
      step     = 4'd15;
      ramp_div = 16'd0;
      for (d = 15; d < 250; d += 15)
         push(d, 0);
      push(250, 1);
      send(250);
      pulse(17);
      push(255, 1);
      send(255);
      pulse(1);
      chk("t3_duty", int'(duty_o), 255);

      // 4: target equals current duty
      push(255, 1);
      send(255);
      chk("t4_busy", int'(busy), 0);
      tick();
      chk("t4_busy2", int'(busy), 0);
      chk("t4_duty", int'(duty_o), 255);

      ena = 1'b0;
      #1;
      chk("idle_ena0_ready", int'(tif.tgt_ready), 1'b0);
      ena = 1'b1;
      tick();

      // 5: freeze with ena=0 mid-ramp
      step     = 4'd10;
      ramp_div = 16'd1;
      push(245, 0);
      push(235, 0);
      send(200);
      pulse(2);
      pulse(1);
      ena = 1'b0;
      #1;
      chk("t5_ready", int'(tif.tgt_ready), 0);
      pulse(3);
      chk("t5_frozen", int'(duty_o), 245);
      ena = 1'b1;
      pulse(1);
      chk("t5_resume", int'(duty_o), 235);

      // 6: asynchronous reset between edges
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_duty", int'(duty_o), 0);
      chk("t6_busy", int'(busy), 0);
      tick();
      rst_n = 1'b1;
      tick();

`ifdef PWM_RAMP_RETARGET_EN
      step     = 4'd5;
      ramp_div = 16'd0;
      push(5, 0);
      push(10, 0);
      push(15, 0);
      push(20, 0);
      push(15, 0);
      push(10, 0);
      push(5, 1);
      send(40);
      pulse(4);
      send(5);
      chk("rt_busy", int'(busy), 1);
      pulse(3);
      chk("rt_duty", int'(duty_o), 5);
`endif

      repeat (3) tick();
      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
